// File: rtl/frame_reception.sv
// frame_reception: byte-serial frame receiver with preamble/SFD hunt, header/payload parse and address filter.
// Define FRAME_RX_FCS_CHECK_EN to append and verify a 4-byte CRC-32 FCS after the payload.
module frame_reception #(
   parameter int unsigned PREAMBLE_LEN  = 7,
   parameter int unsigned PAYLOAD_BYTES = 4,
   parameter bit          PROMISC       = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [7:0]                 rx_in,
   input  logic                       rx_dv,
   input  logic [47:0]                own_addr,
   output logic [47:0]                dest_addr,
   output logic [47:0]                src_addr,
   output logic [15:0]                eth_type,
   output logic [8*PAYLOAD_BYTES-1:0] data_out,
   output logic                       rx_done,
   output logic                       rx_err,
   output logic                       rx_busy
);

   localparam int unsigned DW   = 8 * PAYLOAD_BYTES;
   localparam int unsigned CMAX = (PAYLOAD_BYTES > 6) ? PAYLOAD_BYTES : 6;
   localparam int unsigned CW   = $clog2(CMAX);
   localparam int unsigned PW   = $clog2(PREAMBLE_LEN + 1);

   typedef enum logic [2:0] {
      IDLE,
      PREAMBLE,
      DEST,
      SRC,
      TYPE,
      DATA,
`ifdef FRAME_RX_FCS_CHECK_EN
      FCS,
`endif
      WAIT_IDLE
   } state_t;

   state_t          state;
   logic [PW-1:0]   pre_cnt;
   logic [CW-1:0]   byte_cnt;
   logic [47:0]     dest_sh, src_sh;
   logic [15:0]     type_sh;
   logic [DW-1:0]   data_sh;
   logic [47:0]     dest_nxt, src_nxt;
   logic [15:0]     type_nxt;
   logic [DW-1:0]   data_nxt;
   logic            addr_ok;
   logic            last;

   assign dest_nxt = {dest_sh[39:0], rx_in};
   assign src_nxt  = {src_sh[39:0], rx_in};
   assign type_nxt = {type_sh[7:0], rx_in};
   assign data_nxt = (data_sh << 8) | DW'(rx_in);
   assign addr_ok  = PROMISC || (dest_nxt == own_addr) || (dest_nxt == '1);
   assign rx_busy  = (state != IDLE);

   always_comb begin
      last = 1'b0;
      case (state)
         DEST, SRC: last = (byte_cnt == CW'(5));
         TYPE:      last = (byte_cnt == CW'(1));
         DATA:      last = (byte_cnt == CW'(PAYLOAD_BYTES - 1));
`ifdef FRAME_RX_FCS_CHECK_EN
         FCS:       last = (byte_cnt == CW'(3));
`endif
         default:   last = 1'b0;
      endcase
   end

`ifdef FRAME_RX_FCS_CHECK_EN
   logic [31:0] crc;
   logic [23:0] fcs_sh;
   logic [31:0] fcs_nxt;

   // FCS arrives LS byte first, so new bytes enter at the top
   assign fcs_nxt = {rx_in, fcs_sh};

   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int unsigned i = 0; i < 8; i++)
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         crc <= '1;
      else if (state == PREAMBLE)
         crc <= '1;
      else if (rx_dv && (state inside {DEST, SRC, TYPE, DATA}))
         crc <= crc32_byte(crc, rx_in);
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pre_cnt   <= '0;
         byte_cnt  <= '0;
         dest_sh   <= '0;
         src_sh    <= '0;
         type_sh   <= '0;
         data_sh   <= '0;
         dest_addr <= '0;
         src_addr  <= '0;
         eth_type  <= '0;
         data_out  <= '0;
         rx_done   <= 1'b0;
         rx_err    <= 1'b0;
`ifdef FRAME_RX_FCS_CHECK_EN
         fcs_sh    <= '0;
`endif
      end else begin
         rx_done <= 1'b0;
         rx_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (rx_dv) begin
                  if (rx_in == 8'h55) begin
                     state   <= PREAMBLE;
                     pre_cnt <= PW'(1);
                  end else begin
                     state <= WAIT_IDLE;
                  end
               end
            end
            PREAMBLE: begin
               if (!rx_dv)
                  state <= IDLE;
               else if (rx_in == 8'hD5) begin
                  state    <= DEST;
                  byte_cnt <= '0;
               end else if (rx_in == 8'h55 && pre_cnt < PW'(PREAMBLE_LEN))
                  pre_cnt <= pre_cnt + 1'b1;
               else
                  state <= WAIT_IDLE;
            end
            WAIT_IDLE: begin
               if (!rx_dv)
                  state <= IDLE;
            end
            default: begin
               // All field states share the early-end abort and byte stepping
               if (!rx_dv) begin
                  rx_err <= 1'b1;
                  state  <= IDLE;
               end else begin
                  byte_cnt <= last ? '0 : byte_cnt + 1'b1;
                  case (state)
                     DEST: begin
                        dest_sh <= dest_nxt;
                        if (last) state <= addr_ok ? SRC : WAIT_IDLE;
                     end
                     SRC: begin
                        src_sh <= src_nxt;
                        if (last) state <= TYPE;
                     end
                     TYPE: begin
                        type_sh <= type_nxt;
                        if (last) state <= DATA;
                     end
                     DATA: begin
                        data_sh <= data_nxt;
                        if (last) begin
`ifdef FRAME_RX_FCS_CHECK_EN
                           state <= FCS;
`else
                           state     <= WAIT_IDLE;
                           rx_done   <= 1'b1;
                           dest_addr <= dest_sh;
                           src_addr  <= src_sh;
                           eth_type  <= type_sh;
                           data_out  <= data_nxt;
`endif
                        end
                     end
`ifdef FRAME_RX_FCS_CHECK_EN
                     FCS: begin
                        fcs_sh <= fcs_nxt[31:8];
                        if (last) begin
                           state <= WAIT_IDLE;
                           if (fcs_nxt == ~crc) begin
                              rx_done   <= 1'b1;
                              dest_addr <= dest_sh;
                              src_addr  <= src_sh;
                              eth_type  <= type_sh;
                              data_out  <= data_sh;
                           end else begin
                              rx_err <= 1'b1;
                           end
                        end
                     end
`endif
                     default: state <= IDLE;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_reception.sv
// Directed testbench for frame_reception; covers FCS mode when FRAME_RX_FCS_CHECK_EN is defined.
module tb_frame_reception;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_in;
   logic        rx_dv;
   logic [47:0] own_addr;
   logic [47:0] dest_addr, src_addr;
   logic [15:0] eth_type;
   logic [31:0] data_out;
   logic        rx_done, rx_err, rx_busy;
   logic [47:0] p_dest_addr, p_src_addr;
   logic [15:0] p_eth_type;
   logic [31:0] p_data_out;
   logic        p_done, p_err, p_busy;

   int chk_cnt = 0;
   int pass_cnt = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   int p_done_cnt = 0;

   logic [7:0] fq[$];

`ifdef FRAME_RX_FCS_CHECK_EN
   localparam int FCS_N = 4;
`else
   localparam int FCS_N = 0;
`endif
   localparam logic [47:0] OWN = 48'h1234_5678_9ABC;
   localparam logic [47:0] SRC = 48'hABCD_EF12_3456;

   frame_reception #(.PREAMBLE_LEN(7), .PAYLOAD_BYTES(4), .PROMISC(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .rx_dv(rx_dv), .own_addr(own_addr),
      .dest_addr(dest_addr), .src_addr(src_addr), .eth_type(eth_type), .data_out(data_out),
      .rx_done(rx_done), .rx_err(rx_err), .rx_busy(rx_busy));

   frame_reception #(.PREAMBLE_LEN(7), .PAYLOAD_BYTES(4), .PROMISC(1'b1)) dut_p (
      .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .rx_dv(rx_dv), .own_addr(own_addr),
      .dest_addr(p_dest_addr), .src_addr(p_src_addr), .eth_type(p_eth_type), .data_out(p_data_out),
      .rx_done(p_done), .rx_err(p_err), .rx_busy(p_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_done) done_cnt++;
      if (rx_err) err_cnt++;
      if (rx_done && rx_err) both_cnt++;
      if (p_done) p_done_cnt++;
   end

   function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
         else r = r >> 1;
      end
      return r;
   endfunction

   task automatic build(input logic [47:0] dst, input logic [31:0] dat, input int pre_len, input bit corrupt);
      logic [31:0] c;
      logic [31:0] fcs;
      logic [143:0] body;
      fq.delete();
      for (int i = 0; i < pre_len; i++) fq.push_back(8'h55);
      fq.push_back(8'hD5);
      body = {dst, SRC, 16'h0800, dat};
      c = '1;
      for (int i = 17; i >= 0; i--) begin
         fq.push_back(body[i*8 +: 8]);
         c = crc_model(c, body[i*8 +: 8]);
      end
      fcs = ~c;
      if (FCS_N != 0) begin
         for (int i = 0; i < 4; i++) fq.push_back(fcs[i*8 +: 8]);
         if (corrupt) fq[fq.size()-2] = fq[fq.size()-2] ^ 8'h01;
      end
   endtask

   task automatic drive_byte(input logic [7:0] b);
      rx_dv = 1'b1;
      rx_in = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_n(input int n);
      for (int i = 0; i < n; i++) drive_byte(fq[i]);
   endtask

   task automatic gap(input int n);
      rx_dv = 1'b0;
      rx_in = 8'h00;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      rx_dv = 1'b0;
      rx_in = 8'h00;
      own_addr = OWN;
      repeat (3) @(posedge clk);
      #1;
      chk_cnt++;
      if ({dest_addr, src_addr, eth_type, data_out, rx_done, rx_err, rx_busy} !== '0)
         $display("FAIL reset_outputs: got %h/%h/%h/%h d%b e%b b%b want all 0",
                  dest_addr, src_addr, eth_type, data_out, rx_done, rx_err, rx_busy);
      else pass_cnt++;
      rst_n = 1'b1;
      gap(2);
   endtask

   task automatic test_unicast;
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      build(OWN, 32'hDEAD_BEEF, 7, 1'b0);
      send_n(fq.size());
      chk_cnt++;
      if (rx_done !== 1'b1) $display("FAIL uni_done: got %b want 1", rx_done); else pass_cnt++;
      chk_cnt++;
      if (rx_err !== 1'b0) $display("FAIL uni_err: got %b want 0", rx_err); else pass_cnt++;
      chk_cnt++;
      if (dest_addr !== OWN) $display("FAIL uni_dest: got %h want %h", dest_addr, OWN); else pass_cnt++;
      chk_cnt++;
      if (src_addr !== SRC) $display("FAIL uni_src: got %h want %h", src_addr, SRC); else pass_cnt++;
      chk_cnt++;
      if (eth_type !== 16'h0800) $display("FAIL uni_type: got %h want 0800", eth_type); else pass_cnt++;
      chk_cnt++;
      if (data_out !== 32'hDEAD_BEEF) $display("FAIL uni_data: got %h want deadbeef", data_out); else pass_cnt++;
      gap(2);
      chk_cnt++;
      if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0)
         $display("FAIL uni_pulses: got done %0d err %0d want 1 0", done_cnt - d0, err_cnt - e0);
      else pass_cnt++;
   endtask

   task automatic test_filter;
      int d0, e0, p0;
      d0 = done_cnt; e0 = err_cnt; p0 = p_done_cnt;
      build(48'h6655_4433_2211, 32'h1111_1111, 7, 1'b0);
      send_n(fq.size());
      chk_cnt++;
      if (rx_busy !== 1'b1) $display("FAIL filt_busy: got %b want 1", rx_busy); else pass_cnt++;
      gap(2);
      chk_cnt++;
      if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0)
         $display("FAIL filt_pulses: got done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0);
      else pass_cnt++;
      chk_cnt++;
      if (data_out !== 32'hDEAD_BEEF || dest_addr !== OWN)
         $display("FAIL filt_hold: got %h %h want %h deadbeef", dest_addr, data_out, OWN);
      else pass_cnt++;
      chk_cnt++;
      if (p_done_cnt - p0 !== 1 || p_data_out !== 32'h1111_1111 || p_dest_addr !== 48'h6655_4433_2211)
         $display("FAIL promisc_accept: got done %0d %h %h want 1 665544332211 11111111",
                  p_done_cnt - p0, p_dest_addr, p_data_out);
      else pass_cnt++;
      build(48'hFFFF_FFFF_FFFF, 32'h2222_2222, 7, 1'b0);
      send_n(fq.size());
      chk_cnt++;
      if (rx_done !== 1'b1 || dest_addr !== 48'hFFFF_FFFF_FFFF || data_out !== 32'h2222_2222)
         $display("FAIL bcast_accept: got d%b %h %h want 1 ffffffffffff 22222222", rx_done, dest_addr, data_out);
      else pass_cnt++;
      gap(1);
   endtask

   task automatic test_abort;
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      build(OWN, 32'h3333_3333, 7, 1'b0);
      send_n(8 + 14);
      gap(1);
      chk_cnt++;
      if (rx_err !== 1'b1 || rx_busy !== 1'b0)
         $display("FAIL abort_err: got err %b busy %b want 1 0", rx_err, rx_busy);
      else pass_cnt++;
      gap(1);
      chk_cnt++;
      if (rx_err !== 1'b0) $display("FAIL abort_pulse_len: got %b want 0", rx_err); else pass_cnt++;
      chk_cnt++;
      if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0 || data_out !== 32'h2222_2222 || dest_addr !== 48'hFFFF_FFFF_FFFF)
         $display("FAIL abort_hold: got err %0d done %0d %h %h want 1 0 ffffffffffff 22222222",
                  err_cnt - e0, done_cnt - d0, dest_addr, data_out);
      else pass_cnt++;
      send_n(fq.size());
      chk_cnt++;
      if (rx_done !== 1'b1 || data_out !== 32'h3333_3333 || dest_addr !== OWN)
         $display("FAIL abort_recover: got d%b %h %h want 1 %h 33333333", rx_done, dest_addr, data_out, OWN);
      else pass_cnt++;
      gap(1);
   endtask

   task automatic test_bad_preamble;
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      drive_byte(8'h55);
      drive_byte(8'h55);
      drive_byte(8'hA3);
      build(OWN, 32'h4444_4444, 7, 1'b0);
      send_n(fq.size());
      chk_cnt++;
      if (rx_done !== 1'b0 || rx_busy !== 1'b1)
         $display("FAIL badpre_ignored: got done %b busy %b want 0 1", rx_done, rx_busy);
      else pass_cnt++;
      gap(1);
      build(OWN, 32'h5555_5555, 8, 1'b0);
      send_n(fq.size());
      gap(2);
      chk_cnt++;
      if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0 || data_out !== 32'h3333_3333)
         $display("FAIL longpre_ignored: got done %0d err %0d %h want 0 0 33333333",
                  done_cnt - d0, err_cnt - e0, data_out);
      else pass_cnt++;
      build(OWN, 32'h6666_6666, 1, 1'b0);
      send_n(fq.size());
      chk_cnt++;
      if (rx_done !== 1'b1 || data_out !== 32'h6666_6666)
         $display("FAIL shortpre_accept: got d%b %h want 1 66666666", rx_done, data_out);
      else pass_cnt++;
      gap(1);
   endtask

   task automatic test_back_to_back;
      int d0;
      d0 = done_cnt;
      build(OWN, 32'h0000_0001, 7, 1'b0);
      send_n(fq.size());
      chk_cnt++;
      if (rx_done !== 1'b1 || data_out !== 32'h0000_0001)
         $display("FAIL b2b_first: got d%b %h want 1 00000001", rx_done, data_out);
      else pass_cnt++;
      gap(1);
      build(OWN, 32'h0000_0002, 7, 1'b0);
      send_n(fq.size());
      chk_cnt++;
      if (rx_done !== 1'b1 || data_out !== 32'h0000_0002)
         $display("FAIL b2b_second: got d%b %h want 1 00000002", rx_done, data_out);
      else pass_cnt++;
      gap(1);
      chk_cnt++;
      if (done_cnt - d0 !== 2) $display("FAIL b2b_count: got %0d want 2", done_cnt - d0); else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      int e0;
      e0 = err_cnt;
      build(OWN, 32'h7777_7777, 7, 1'b0);
      send_n(8 + 14 + 2);
      rst_n = 1'b0;
      rx_dv = 1'b0;
      #1;
      chk_cnt++;
      if ({dest_addr, src_addr, eth_type, data_out, rx_done, rx_err, rx_busy} !== '0)
         $display("FAIL rstmid_async: got %h/%h/%h/%h busy %b want all 0",
                  dest_addr, src_addr, eth_type, data_out, rx_busy);
      else pass_cnt++;
      gap(2);
      rst_n = 1'b1;
      gap(1);
      chk_cnt++;
      if (err_cnt - e0 !== 0) $display("FAIL rstmid_no_err: got %0d want 0", err_cnt - e0); else pass_cnt++;
      send_n(fq.size());
      chk_cnt++;
      if (rx_done !== 1'b1 || data_out !== 32'h7777_7777)
         $display("FAIL rstmid_recover: got d%b %h want 1 77777777", rx_done, data_out);
      else pass_cnt++;
      gap(1);
   endtask

`ifdef FRAME_RX_FCS_CHECK_EN
   task automatic test_fcs_bad;
      int d0;
      d0 = done_cnt;
      build(OWN, 32'h8888_8888, 7, 1'b1);
      send_n(fq.size());
      chk_cnt++;
      if (rx_err !== 1'b1 || rx_done !== 1'b0)
         $display("FAIL fcs_bad: got err %b done %b want 1 0", rx_err, rx_done);
      else pass_cnt++;
      gap(2);
      chk_cnt++;
      if (done_cnt - d0 !== 0 || data_out !== 32'h7777_7777)
         $display("FAIL fcs_bad_hold: got done %0d %h want 0 77777777", done_cnt - d0, data_out);
      else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_unicast();
      test_filter();
      test_abort();
      test_bad_preamble();
      test_back_to_back();
      test_reset_mid();
`ifdef FRAME_RX_FCS_CHECK_EN
      test_fcs_bad();
`endif
      chk_cnt++;
      if (both_cnt !== 0) $display("FAIL done_err_overlap: got %0d want 0", both_cnt); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/frame_reception.md
Name: frame_reception

Overview:
- Byte-serial Ethernet-style frame receiver; the receive-side counterpart of frame_transmission.
- Consumes an 8-bit byte stream qualified by rx_dv and hunts for preamble/SFD.
- Parses destination address, source address, EtherType and a fixed-size payload; applies destination-address filtering.
- Presents the decoded fields with a one-cycle done strobe to the MAC receive path.

Parameters:
- PREAMBLE_LEN, 7: maximum number of 0x55 preamble bytes accepted before the SFD.
- PAYLOAD_BYTES, 4: payload length in bytes; data_out width is 8*PAYLOAD_BYTES.
- PROMISC, 0: 1 = accept every destination address; 0 = filter on own_addr or broadcast.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_in  input  8  received byte, sampled when rx_dv=1.
- rx_dv  input  1  byte-valid / frame-envelope qualifier.
- own_addr  input  48  station MAC address, used for filtering.
- dest_addr  output  48  destination address of the last good frame.
- src_addr  output  48  source address of the last good frame.
- eth_type  output  16  EtherType of the last good frame.
- data_out  output  8*PAYLOAD_BYTES  payload of the last good frame.
- rx_done  output  1  one-cycle pulse: the field outputs have just been updated.
- rx_err  output  1  one-cycle pulse: frame aborted or failed its check.
- rx_busy  output  1  high while in any state other than IDLE.

Behaviour:
- Reset: async on rst_n=0. All outputs go to 0 and the FSM goes to IDLE. Reset mid-frame discards the frame with no rx_err.
- Byte order: all multi-byte fields arrive MS byte first, in this sequence: dest (6), src (6), type (2), payload (PAYLOAD_BYTES).
- Shadow registers: fields are assembled in shadow registers. Outputs update only on a good frame, on the same edge that raises rx_done. Outputs hold their last values otherwise.
- FSM states: IDLE, PREAMBLE, DEST, SRC, TYPE, DATA, [FCS], WAIT_IDLE.
- IDLE:
  - rx_dv=1 && rx_in=0x55 -> PREAMBLE, with preamble count=1.
  - rx_dv=1 with any other byte -> WAIT_IDLE.
- PREAMBLE:
  - 0x55 with count<PREAMBLE_LEN -> stay, count++.
  - 0xD5 -> DEST.
  - Any other byte, or 0x55 with count=PREAMBLE_LEN -> WAIT_IDLE (silent drop).
- Field states: a byte counter steps through each field and resets to 0 on each state change.
- Address filter: evaluated after the 6th dest byte. Pass if dest==own_addr, dest==48'hFFFF_FFFF_FFFF, or PROMISC=1. Fail -> WAIT_IDLE, silently, with no rx_err.
- DATA: on the last payload byte, the next state is WAIT_IDLE (or FCS when the option is enabled). rx_done pulses high in the following cycle, i.e. 1-clock latency from sampling the last byte.
- Early end: rx_dv=0 in any state from PREAMBLE through the last expected byte -> rx_err for one cycle, then IDLE. No output update.
  - Exception: rx_dv=0 in PREAMBLE -> IDLE silently.
- WAIT_IDLE: extra bytes are ignored while rx_dv=1. rx_dv=0 -> IDLE. A new frame needs at least 1 cycle of rx_dv=0 between frames.
- rx_done and rx_err are never high in the same cycle.

Optional Feature:
- Macro: FRAME_RX_FCS_CHECK_EN.
- Defined:
  - After the payload the FSM enters FCS and expects 4 more bytes.
  - CRC-32 (IEEE 802.3: reflected poly 0x04C11DB7, init 0xFFFFFFFF, final XOR 0xFFFFFFFF) is computed over dest through payload, processed LSB-first per byte.
  - The received FCS arrives LS byte first.
  - Match -> rx_done 1 cycle after the 4th FCS byte.
  - Mismatch -> rx_err pulse with no output update; fields are not updated.
  - rx_dv dropping during FCS -> rx_err.
- Undefined: no FCS state and no CRC logic. rx_done follows the last payload byte as described above.

Test Plan:
- Good unicast:
  - Stimulus: own_addr=123456789ABC; 7x55, D5, dest 123456789ABC, src ABCDEF123456, type 0800, data DEADBEEF (plus correct FCS if FCS enabled).
  - Response: rx_done pulses once 1 cycle after the last byte; outputs show exactly those values; rx_err=0.
- Filtering:
  - Dest 665544332211 -> no rx_done, no rx_err, outputs unchanged.
  - Dest FFFFFFFFFFFF -> accepted.
  - PROMISC=1 with dest 665544332211 -> accepted.
- Abort: rx_dv drops after the 2nd type byte -> single rx_err pulse, FSM returns to IDLE, outputs keep their previous frame values. A following good frame is received correctly.
- Bad preamble: 55 55 A3 then a valid-looking frame without a gap -> ignored. After rx_dv low for 1 cycle, the next good frame -> rx_done.
- Back-to-back: two good frames separated by 1 idle cycle, with data 00000001 then 00000002 -> two rx_done pulses; data_out shows each value in turn.
- Reset mid-DATA: assert rst_n=0 -> all outputs 0 immediately (asynchronous), no rx_err. After release, a good frame is received. If FCS is enabled: one corrupted FCS byte -> rx_err, no rx_done.
